// File: rtl/stream_framer_if.sv
// Valid/ready/last stream bundle shared by the byte side and the word side of stream_framer.
interface stream_framer_if #(parameter int W = 8) ();
   logic [W-1:0] data;
   logic         val;
   logic         ready;
   logic         last;

   modport master (output data, val, last, input ready);
   modport slave  (input data, val, last, output ready);
endinterface

// File: rtl/stream_framer.sv
// Packs a length-framed byte stream into big-endian 32-bit words with word-level last framing.
// Optional feature macro FRAMER_STATS_EN adds pktCount, a wrapping count of popped last words.
module stream_framer #(
   parameter int MIN_LEN   = 8,
   parameter int MAX_LEN   = 45,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_b,
   stream_framer_if.slave       byteIn,
   stream_framer_if.master      dataOut,
   output logic                 errPulse,
   output logic [ERR_CNT_W-1:0] errCount
`ifdef FRAMER_STATS_EN
   ,
   output logic [31:0]          pktCount
`endif
);

   typedef enum logic [1:0] {HDR = 2'd0, BODY = 2'd1, FLUSH = 2'd2, DISCARD = 2'd3} state_t;

   localparam logic [15:0] MIN_L     = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L     = 16'(MAX_LEN);
   localparam logic [1:0]  FIFO_FULL = 2'd2;

   state_t               stateR;
   logic [1:0]           idxR;
   logic [31:0]          accR;
   logic [15:0]          remR;
   logic                 firstWordR;
   logic                 liveR;
   logic [31:0]          headR;
   logic [31:0]          tailR;
   logic                 headLastR;
   logic                 tailLastR;
   logic [1:0]           cntR;
   logic                 errPulseR;
   logic [ERR_CNT_W-1:0] errCountR;

   logic                 takeS;
   logic                 popS;
   logic                 pushS;
   logic                 pushLastS;
   logic                 errS;
   logic                 lenBadS;
   logic [15:0]          lenS;
   logic [31:0]          wordS;
   logic [31:0]          pushWordS;

   // liveR keeps the input closed until the first clock after reset release.
   assign byteIn.ready = liveR && (cntR != FIFO_FULL) && (stateR != FLUSH);
   assign dataOut.data = headR;
   assign dataOut.val  = (cntR != 2'd0);
   assign dataOut.last = headLastR;
   assign errPulse     = errPulseR;
   assign errCount     = errCountR;

   // Decode this cycle's transfers, the word to push and any framing error.
   always_comb begin
      takeS     = byteIn.val && byteIn.ready;
      popS      = dataOut.val && dataOut.ready;
      lenS      = {accR[31:24], byteIn.data};
      lenBadS   = (lenS < MIN_L) || (lenS > MAX_L);
      wordS     = accR | ({byteIn.data, 24'h000000} >> {idxR, 3'b000});
      pushS     = 1'b0;
      pushLastS = 1'b0;
      pushWordS = wordS;
      errS      = 1'b0;
      case (stateR)
         HDR: begin
            if (takeS && byteIn.last) begin
               errS = 1'b1;
            end else if (takeS && (idxR == 2'd1) && lenBadS) begin
               errS = 1'b1;
            end else if (takeS && (idxR == 2'd3)) begin
               pushS = 1'b1;
            end else begin
               pushS = 1'b0;
            end
         end
         BODY: begin
            if (takeS && ((remR == 16'd1) || byteIn.last)) begin
               pushS     = 1'b1;
               pushLastS = 1'b1;
               errS      = (remR != 16'd1) || !byteIn.last;
            end else if (takeS && (idxR == 2'd3)) begin
               pushS = 1'b1;
            end else begin
               pushS = 1'b0;
            end
         end
         FLUSH: begin
            if (cntR != FIFO_FULL) begin
               pushS     = 1'b1;
               pushLastS = 1'b1;
               pushWordS = 32'h0000_0000;
            end else begin
               pushS = 1'b0;
            end
         end
         DISCARD: pushS = 1'b0;
         default: pushS = 1'b0;
      endcase
   end

   // Packet state machine: header checks, lane packing and remaining-byte count.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         stateR     <= HDR;
         idxR       <= 2'd0;
         accR       <= 32'h0000_0000;
         remR       <= 16'h0000;
         firstWordR <= 1'b0;
         liveR      <= 1'b0;
      end else begin
         liveR <= 1'b1;
         case (stateR)
            HDR: if (takeS) begin
               if (byteIn.last || ((idxR == 2'd1) && lenBadS)) begin
                  stateR <= byteIn.last ? HDR : DISCARD;
                  idxR   <= 2'd0;
                  accR   <= 32'h0000_0000;
               end else if (idxR == 2'd3) begin
                  stateR     <= BODY;
                  idxR       <= 2'd0;
                  accR       <= 32'h0000_0000;
                  remR       <= remR - 16'd1;
                  firstWordR <= 1'b1;
               end else begin
                  accR <= wordS;
                  idxR <= idxR + 2'd1;
                  remR <= (idxR == 2'd1) ? (lenS - 16'd2) : (remR - 16'd1);
               end
            end
            BODY: if (takeS) begin
               remR <= remR - 16'd1;
               if ((remR == 16'd1) || byteIn.last) begin
                  idxR       <= 2'd0;
                  accR       <= 32'h0000_0000;
                  firstWordR <= 1'b0;
                  // A truncation inside the second header word still owes the parser a closing word.
                  if (remR == 16'd1) begin
                     stateR <= byteIn.last ? HDR : DISCARD;
                  end else begin
                     stateR <= firstWordR ? FLUSH : HDR;
                  end
               end else if (idxR == 2'd3) begin
                  idxR       <= 2'd0;
                  accR       <= 32'h0000_0000;
                  firstWordR <= 1'b0;
               end else begin
                  accR <= wordS;
                  idxR <= idxR + 2'd1;
               end
            end
            FLUSH:   if (cntR != FIFO_FULL) stateR <= HDR;
            DISCARD: if (takeS && byteIn.last) stateR <= HDR;
            default: stateR <= HDR;
         endcase
      end
   end

   // Two-entry output FIFO; the head register drives dataOut directly.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         headR     <= 32'h0000_0000;
         tailR     <= 32'h0000_0000;
         headLastR <= 1'b0;
         tailLastR <= 1'b0;
         cntR      <= 2'd0;
      end else begin
         case ({pushS, popS})
            2'b10: begin
               if (cntR == 2'd0) begin
                  headR     <= pushWordS;
                  headLastR <= pushLastS;
               end else begin
                  tailR     <= pushWordS;
                  tailLastR <= pushLastS;
               end
               cntR <= cntR + 2'd1;
            end
            2'b01: begin
               headR     <= tailR;
               headLastR <= tailLastR;
               cntR      <= cntR - 2'd1;
            end
            2'b11: begin
               if (cntR == 2'd1) begin
                  headR     <= pushWordS;
                  headLastR <= pushLastS;
               end else begin
                  headR     <= tailR;
                  headLastR <= tailLastR;
                  tailR     <= pushWordS;
                  tailLastR <= pushLastS;
               end
            end
            default: cntR <= cntR;
         endcase
      end
   end

   // Registered error strobe and saturating error count.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         errPulseR <= 1'b0;
         errCountR <= {ERR_CNT_W{1'b0}};
      end else begin
         errPulseR <= errS;
         if (errS && (errCountR != {ERR_CNT_W{1'b1}})) begin
            errCountR <= errCountR + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

`ifdef FRAMER_STATS_EN
   logic [31:0] pktCountR;
   assign pktCount = pktCountR;

   // Wrapping count of words leaving the FIFO with last set.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         pktCountR <= 32'h0000_0000;
      end else if (popS && headLastR) begin
         pktCountR <= pktCountR + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_stream_framer.sv
// Randomized bench for stream_framer: packet-level reference model plus directed framing cases.
module tb_stream_framer;
   localparam int ERR_W   = 4;
   localparam int SAT_MAX = (1 << ERR_W) - 1;

   logic             clk;
   logic             reset_b;
   logic             errPulse;
   logic [ERR_W-1:0] errCount;
`ifdef FRAMER_STATS_EN
   logic [31:0]      pktCount;
`endif

   stream_framer_if #(.W(8))  byteIf ();
   stream_framer_if #(.W(32)) wordIf ();

   stream_framer #(.MIN_LEN(8), .MAX_LEN(45), .ERR_CNT_W(ERR_W)) dut (
      .clk      (clk),
      .reset_b  (reset_b),
      .byteIn   (byteIf),
      .dataOut  (wordIf),
      .errPulse (errPulse),
      .errCount (errCount)
`ifdef FRAMER_STATS_EN
      ,
      .pktCount (pktCount)
`endif
   );

   int          nCompared   = 0;
   int          nMismatched = 0;
   int          errExp      = 0;
   int          pulses      = 0;
   int          pktExp      = 0;
   logic [32:0] expQ[$];
   logic [7:0]  frame[$];
   logic [32:0] monExp;
   bit          holdReady   = 1'b0;
   bit          gapsOn      = 1'b1;
   bit          sendDone    = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Downstream ready: random backpressure unless a test holds it low.
   initial begin
      wordIf.ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         wordIf.ready = holdReady ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Scoreboard: every popped word must match the head of the expected queue.
   always @(negedge clk) begin
      if (reset_b) begin
         if (errPulse) pulses++;
         if (wordIf.val && wordIf.ready) begin
            if (expQ.size() == 0) begin
               checkVal("extraWord", 64'(expQ.size()), 64'd1);
            end else begin
               monExp = expQ.pop_front();
               checkVal("word", 64'({wordIf.last, wordIf.data}), 64'(monExp));
               if (monExp[32]) pktExp++;
            end
         end
      end
   end

   task automatic expectWord(input logic last, input logic [31:0] w);
      expQ.push_back({last, w});
   endtask

   // Reference: a MAC frame is judged whole from its length field and its byte count.
   task automatic modelFrame();
      int          n;
      int          len;
      int          m;
      logic [31:0] w;
      n = frame.size();
      if (n < 2) begin
         errExp++;
         return;
      end
      len = {frame[0], frame[1]};
      if (len < 8 || len > 45 || n <= 4) begin
         errExp++;
         return;
      end
      m = (n < len) ? n : len;
      for (int i = 0; i < m; i += 4) begin
         w = 32'h0;
         for (int k = 0; k < 4; k++) begin
            if (i + k < m) w[31 - 8*k -: 8] = frame[i + k];
         end
         expQ.push_back({(i + 4 >= m), w});
      end
      if (n != len) errExp++;
      if (n < len && n <= 8) expQ.push_back({1'b1, 32'h0});
   endtask

   task automatic genRandom();
      int kind;
      int len;
      int n;
      kind = $urandom_range(0, 5);
      len  = $urandom_range(8, 45);
      case (kind)
         1: n = $urandom_range(5, len - 1);
         2: n = len + $urandom_range(1, 6);
         3: begin
            len = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(46, 400);
            n   = $urandom_range(2, 30);
         end
         4: n = $urandom_range(1, 4);
         default: n = len;
      endcase
      frame.delete();
      frame.push_back(len[15:8]);
      frame.push_back(len[7:0]);
      for (int i = 2; i < n; i++) frame.push_back(8'($urandom_range(0, 255)));
      while (frame.size() > n) void'(frame.pop_back());
   endtask

   task automatic sendByte(input logic [7:0] b, input logic l);
      int   guard;
      logic accepted;
      if (gapsOn && $urandom_range(0, 3) == 0) begin
         repeat ($urandom_range(1, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      byteIf.data = b;
      byteIf.val  = 1'b1;
      byteIf.last = l;
      guard       = 0;
      accepted    = 1'b0;
      do begin
         @(negedge clk);
         accepted = byteIf.ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!accepted && guard < 300);
      byteIf.val  = 1'b0;
      byteIf.last = 1'b0;
      checkVal("byteAccepted", 64'(accepted), 64'd1);
   endtask

   task automatic sendFrame();
      @(posedge clk);
      #1;
      for (int i = 0; i < frame.size(); i++) sendByte(frame[i], (i == frame.size() - 1));
   endtask

   task automatic waitDrain();
      int guard = 0;
      while (expQ.size() != 0 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      checkVal("drain", 64'(expQ.size()), 64'd0);
      repeat (4) @(negedge clk);
   endtask

   task automatic checkTallies(input string tag);
      checkVal({tag, "_errCount"}, 64'(errCount), 64'((errExp > SAT_MAX) ? SAT_MAX : errExp));
      checkVal({tag, "_errPulses"}, 64'(pulses), 64'(errExp));
`ifdef FRAMER_STATS_EN
      checkVal({tag, "_pktCount"}, 64'(pktCount), 64'(pktExp));
`endif
   endtask

   task automatic runLegal12();
      frame = '{8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h07,
                8'hAA, 8'hBB, 8'hCC, 8'hDD};
      expectWord(1'b0, 32'h000C0003);
      expectWord(1'b0, 32'h00000007);
      expectWord(1'b1, 32'hAABBCCDD);
      sendFrame();
      waitDrain();
   endtask

   initial begin
      reset_b     = 1'b0;
      byteIf.val  = 1'b0;
      byteIf.last = 1'b0;
      byteIf.data = 8'h00;
      repeat (3) @(negedge clk);
      checkVal("rstVal", 64'(wordIf.val), 64'd0);
      checkVal("rstData", 64'(wordIf.data), 64'd0);
      checkVal("rstLast", 64'(wordIf.last), 64'd0);
      checkVal("rstErrPulse", 64'(errPulse), 64'd0);
      checkVal("rstErrCount", 64'(errCount), 64'd0);
      reset_b = 1'b1;
      @(posedge clk);
      #1;
      checkVal("readyAfterReset", 64'(byteIf.ready), 64'd1);

      runLegal12();
      checkTallies("legal12");

      frame = '{8'h00, 8'h0D, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h07,
                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      expectWord(1'b0, 32'h000D0003);
      expectWord(1'b0, 32'h00000007);
      expectWord(1'b0, 32'hAABBCCDD);
      expectWord(1'b1, 32'hEE000000);
      sendFrame();
      waitDrain();
      checkTallies("legal13");

      frame.delete();
      frame.push_back(8'h00);
      frame.push_back(8'h32);
      for (int i = 2; i < 20; i++) frame.push_back(8'($urandom_range(0, 255)));
      errExp++;
      sendFrame();
      waitDrain();
      checkTallies("badLen50");
      runLegal12();
      checkTallies("afterBadLen");

      frame = '{8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h07, 8'hAA, 8'hBB};
      expectWord(1'b0, 32'h000C0003);
      expectWord(1'b0, 32'h00000007);
      expectWord(1'b1, 32'hAABB0000);
      errExp++;
      sendFrame();
      waitDrain();
      checkTallies("truncated");

      frame = '{8'h00, 8'h09, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h07,
                8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      expectWord(1'b0, 32'h00090003);
      expectWord(1'b0, 32'h00000007);
      expectWord(1'b1, 32'hAA000000);
      errExp++;
      sendFrame();
      waitDrain();
      checkTallies("overLong");

      // Backpressure: output held off while a 20-byte packet streams in.
      holdReady = 1'b1;
      gapsOn    = 1'b0;
      @(posedge clk);
      #2;
      frame.delete();
      frame.push_back(8'h00);
      frame.push_back(8'h14);
      for (int i = 2; i < 20; i++) frame.push_back(8'($urandom_range(0, 255)));
      modelFrame();
      sendDone = 1'b0;
      fork
         begin
            sendFrame();
            sendDone = 1'b1;
         end
      join_none
      repeat (11) @(negedge clk);
      checkVal("bpByteReady", 64'(byteIf.ready), 64'd0);
      checkVal("bpWordVal", 64'(wordIf.val), 64'd1);
      holdReady = 1'b0;
      for (int g = 0; g < 2000 && !sendDone; g++) @(negedge clk);
      checkVal("bpSendDone", 64'(sendDone), 64'd1);
      waitDrain();
      gapsOn = 1'b1;
      checkTallies("backpressure");

      for (int f = 0; f < 200; f++) begin
         genRandom();
         modelFrame();
         sendFrame();
         if (f % 50 == 49) begin
            waitDrain();
            checkTallies("random");
         end
      end

      // Reset in the middle of a packet with a word still buffered.
      holdReady = 1'b1;
      gapsOn    = 1'b0;
      @(posedge clk);
      #2;
      frame = '{8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00};
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) sendByte(frame[i], 1'b0);
      #3;
      checkVal("preResetVal", 64'(wordIf.val), 64'd1);
      reset_b = 1'b0;
      #1;
      checkVal("midRstVal", 64'(wordIf.val), 64'd0);
      checkVal("midRstLast", 64'(wordIf.last), 64'd0);
      checkVal("midRstErrCount", 64'(errCount), 64'd0);
      expQ.delete();
      errExp = 0;
      pulses = 0;
      pktExp = 0;
      repeat (2) @(negedge clk);
      reset_b   = 1'b1;
      holdReady = 1'b0;
      gapsOn    = 1'b1;
      @(posedge clk);
      #1;
      checkVal("readyAfterMidRst", 64'(byteIf.ready), 64'd1);
      runLegal12();
      checkTallies("afterMidRst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule

// File: doc/stream_framer.md
Name: stream_framer

Overview:
- Upstream neighbour of the sequence parser. Accepts a byte stream from the link MAC, with a last flag per packet.
- Packs bytes big-endian into 32-bit words and asserts a last flag on the word holding the final byte named by the packet's length field.
- Drops malformed packets, truncates over-long ones, and zero-pads short ones, so the parser always sees well-formed word framing.

Parameters:
- MIN_LEN, 8: smallest legal length field in bytes (header only).
- MAX_LEN, 45: largest legal length field (8-byte header + 37-byte payload).
- ERR_CNT_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  clock
- reset_b  in  1  asynchronous active-low reset
- byteIn  in  8  input byte
- byteIn_val  in  1  byteIn valid
- byteIn_ready  out  1  framer can accept a byte
- byteIn_last  in  1  byte is the final byte of the MAC frame
- dataOut  out  32  packed word; first byte in [31:24]
- dataOut_val  out  1  word valid
- dataOut_ready  in  1  downstream accepts word
- dataOut_last  out  1  word carries the final packet byte
- errPulse  out  1  one-cycle strobe per detected error
- errCount  out  ERR_CNT_W  saturating count of errors

Behaviour:
- Reset is asynchronous and active-low: reset_b low clears all state immediately, independent of clk. On reset:
  - state = HDR; accumulator and byte index = 0; FIFO emptied.
  - dataOut_val = 0, dataOut_last = 0, dataOut = 0.
  - errPulse = 0, errCount = 0.
  - byteIn_ready is 1 from the first clock after reset release.
- Reset mid-packet discards the partial packet; nothing is emitted for it.
- Byte transfer: occurs when byteIn_val && byteIn_ready. Word transfer: occurs when dataOut_val && dataOut_ready.
- Output buffer: 2-entry FIFO. dataOut/dataOut_val/dataOut_last come from the FIFO head.
- byteIn_ready = (FIFO count < 2) && state != FLUSH. It is registered-derived, with no combinational path from dataOut_ready.
- Packing: accepted bytes fill accumulator lanes [31:24], [23:16], [15:8], [7:0] in order.
  - On lane 3, or on packet end, the word is pushed the same cycle; unused lanes are 0.
  - Latency: byte accepted at cycle N, word visible on dataOut at N+1.
- Length: bytes 0-1 form len[15:0]. A remaining-byte counter (16 bit) is loaded with len-2 after byte 1 and decremented per accepted byte.
- State machine:
  - HDR: collecting bytes 0..3.
    - After byte 1: if len < MIN_LEN or len > MAX_LEN → errPulse, go DISCARD, clear the accumulator (nothing pushed).
    - byteIn_last on bytes 0..3 → runt: drop the packet (nothing pushed), errPulse, stay HDR.
    - Byte 3 accepted with legal length → push word, go BODY.
  - BODY: pack bytes.
    - Counter reaching 0 on an accepted byte → push word with last = 1. If byteIn_last is not set on that byte → errPulse, go DISCARD; otherwise go HDR.
    - byteIn_last with counter > 1 (truncated) → push a zero-padded word with last = 1, errPulse. Go FLUSH only if the word is a header-only packet (see below); otherwise go HDR.
  - FLUSH: entered only when a truncated packet ends before the sequence word. Emits one all-zero word with last = 1 so the parser completes its header, then returns to HDR. byteIn_ready = 0 during FLUSH. If the FIFO is full, FLUSH waits.
  - DISCARD: byteIn_ready follows the normal rule; all bytes are dropped; byteIn_last → HDR.
- Simultaneous push and pop in the same cycle keep the FIFO count unchanged. Push is never attempted when the FIFO is full, guaranteed by the ready rule.
- errCount increments on each errPulse and saturates at all-ones.

Optional Feature:
- FRAMER_STATS_EN defined: adds output pktCount [31:0], counting words popped with dataOut_last = 1. It wraps at 2^32 and resets to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Legal packet len = 12, bytes 00 0C 00 03 00 00 00 07 AA BB CC DD with last on byte 11 → words 000C0003, 00000007, AABBCCDD (last = 1); errCount = 0.
- len = 13, 13 bytes ending EE (last) → 4th word EE000000 with last = 1; no error.
- len = 50 (> MAX_LEN) in 20 bytes → no words emitted; errPulse once; errCount = 1; next legal packet emitted intact.
- len = 12, but byteIn_last on byte 9 → third word = {b8, b9, 00, 00} with last = 1; errCount increments.
- len = 9, 15 bytes sent → third word {b8, 00, 00, 00} with last = 1; bytes 9..14 discarded; errPulse once.
- dataOut_ready held 0 for 10 cycles mid-packet → byteIn_ready drops after 2 words buffered; no byte lost or duplicated after release. reset_b pulsed low mid-packet → dataOut_val = 0 immediately; the next packet frames correctly.
